// File: rtl/rep_umul.sv
// rep_umul: unipolar stochastic multiplier using a unary A stream and a bit-reversed B stream
module rep_umul #(
    parameter int BITWIDTH = 8
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic [BITWIDTH-1:0] A,
    input  logic [BITWIDTH-1:0] B,
    input  logic                loadB,
    input  logic                iEn,
    input  logic                iClr,
    output logic [BITWIDTH-1:0] mult
);
    logic [BITWIDTH-1:0] breg_q, breg_d;
    logic [BITWIDTH-1:0] cnt_q, cnt_d;
    logic [BITWIDTH-1:0] acc_q, acc_d;
    logic [BITWIDTH-1:0] mult_q, mult_d;
    logic [BITWIDTH-1:0] rev_cnt;
    logic                a_bit, b_bit, prod, last;
    logic [BITWIDTH-1:0] acc_sum;

    // Bit-reverse the window counter to give B a low-discrepancy sequence uncorrelated with A's unary ramp
    always_comb begin
        rev_cnt = '0;
        for (int i = 0; i < BITWIDTH; i++) rev_cnt[i] = cnt_q[BITWIDTH-1-i];
    end

    assign a_bit   = A > cnt_q;
    assign b_bit   = breg_q > rev_cnt;
    assign prod    = a_bit & b_bit;
    assign last    = &cnt_q;
    assign acc_sum = acc_q + BITWIDTH'(prod);

    // Next state: clear beats enable; the last window cycle publishes the count and restarts the accumulator
    always_comb begin
        breg_d = loadB ? B : breg_q;
        cnt_d  = iClr ? '0 : iEn ? cnt_q + BITWIDTH'(1) : cnt_q;
        acc_d  = iClr ? '0 : !iEn ? acc_q : last ? '0 : acc_sum;
        mult_d = iClr ? '0 : (iEn && last) ? acc_sum : mult_q;
    end

    // State registers with asynchronous reset
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            breg_q <= '0;
            cnt_q  <= '0;
            acc_q  <= '0;
            mult_q <= '0;
        end else begin
            breg_q <= breg_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            mult_q <= mult_d;
        end
    end

    assign mult = mult_q;
endmodule

// File: tb/tb_rep_umul.sv
// tb_rep_umul: directed checks of rep_umul window results, pause, clear, reset and B loading
module tb_rep_umul;
    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic       loadB = 1'b0;
    logic       iEn = 1'b0;
    logic       iClr = 1'b0;
    logic [7:0] mult;
    int         n_chk = 0;
    int         n_fail = 0;

    rep_umul #(.BITWIDTH(8)) dut (
        .iClk(iClk), .iRst(iRst), .A(A), .B(B), .loadB(loadB),
        .iEn(iEn), .iClr(iClr), .mult(mult)
    );

    always #5 iClk = ~iClk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge iClk);
            #1;
        end
    endtask

    task automatic run(input int n);
        iEn = 1'b1;
        tick(n);
        iEn = 1'b0;
    endtask

    task automatic load_b(input logic [7:0] v);
        B = v;
        loadB = 1'b1;
        tick(1);
        loadB = 1'b0;
    endtask

    task automatic clear();
        iClr = 1'b1;
        tick(1);
        iClr = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_chk++;
        if (mult !== 8'd0) begin n_fail++; $display("FAIL reset_value: got %0d want 0", mult); end
        iRst = 1'b0;
        tick(1);
    endtask

    task automatic test_basic();
        load_b(8'd128);
        A = 8'd134;
        run(255);
        n_chk++;
        if (mult !== 8'd0) begin n_fail++; $display("FAIL basic_before_end: got %0d want 0", mult); end
        run(1);
        n_chk++;
        if (mult !== 8'd67) begin n_fail++; $display("FAIL basic_window1: got %0d want 67", mult); end
        tick(10);
        n_chk++;
        if (mult !== 8'd67) begin n_fail++; $display("FAIL basic_idle_hold: got %0d want 67", mult); end
        run(500);
        n_chk++;
        if (mult !== 8'd67) begin n_fail++; $display("FAIL basic_window2: got %0d want 67", mult); end
    endtask

    task automatic test_extremes();
        clear();
        load_b(8'd255);
        A = 8'd255;
        run(256);
        n_chk++;
        if (mult !== 8'd255) begin n_fail++; $display("FAIL max_operands: got %0d want 255", mult); end
        A = 8'd0;
        run(256);
        n_chk++;
        if (mult !== 8'd0) begin n_fail++; $display("FAIL a_zero: got %0d want 0", mult); end
        A = 8'd64;
        run(256);
        n_chk++;
        if (mult !== 8'd64) begin n_fail++; $display("FAIL a64_bmax: got %0d want 64", mult); end
        load_b(8'd0);
        A = 8'd255;
        run(256);
        n_chk++;
        if (mult !== 8'd0) begin n_fail++; $display("FAIL b_zero: got %0d want 0", mult); end
    endtask

    task automatic test_pause();
        clear();
        load_b(8'd64);
        A = 8'd128;
        run(100);
        tick(50);
        n_chk++;
        if (mult !== 8'd0) begin n_fail++; $display("FAIL pause_hold: got %0d want 0", mult); end
        run(156);
        n_chk++;
        if (mult !== 8'd32) begin n_fail++; $display("FAIL pause_resume: got %0d want 32", mult); end
    endtask

    task automatic test_clear();
        clear();
        load_b(8'd128);
        A = 8'd134;
        run(256);
        n_chk++;
        if (mult !== 8'd67) begin n_fail++; $display("FAIL clear_pre: got %0d want 67", mult); end
        run(100);
        iEn = 1'b1;
        iClr = 1'b1;
        tick(1);
        iClr = 1'b0;
        n_chk++;
        if (mult !== 8'd0) begin n_fail++; $display("FAIL clear_mid: got %0d want 0", mult); end
        run(256);
        n_chk++;
        if (mult !== 8'd67) begin n_fail++; $display("FAIL clear_after: got %0d want 67", mult); end
    endtask

    task automatic test_async_reset();
        run(100);
        #2 iRst = 1'b1;
        #1;
        n_chk++;
        if (mult !== 8'd0) begin n_fail++; $display("FAIL async_reset_now: got %0d want 0", mult); end
        #1 iRst = 1'b0;
        A = 8'd200;
        tick(1);
        run(256);
        n_chk++;
        if (mult !== 8'd0) begin n_fail++; $display("FAIL reset_breg_zero: got %0d want 0", mult); end
        load_b(8'd128);
        A = 8'd134;
        run(256);
        n_chk++;
        if (mult !== 8'd67) begin n_fail++; $display("FAIL reset_reload: got %0d want 67", mult); end
    endtask

    task automatic test_loadb_idle();
        clear();
        load_b(8'd64);
        A = 8'd128;
        run(256);
        n_chk++;
        if (mult !== 8'd32) begin n_fail++; $display("FAIL loadb_pre: got %0d want 32", mult); end
        run(100);
        load_b(8'd255);
        n_chk++;
        if (mult !== 8'd32) begin n_fail++; $display("FAIL loadb_idle_mult: got %0d want 32", mult); end
        tick(3);
        run(156);
        n_chk++;
        if (mult !== 8'd53) begin n_fail++; $display("FAIL loadb_mixed_window: got %0d want 53", mult); end
    endtask

    task automatic test_load_and_clear();
        B = 8'd128;
        loadB = 1'b1;
        iClr = 1'b1;
        tick(1);
        loadB = 1'b0;
        iClr = 1'b0;
        n_chk++;
        if (mult !== 8'd0) begin n_fail++; $display("FAIL load_clear_mult: got %0d want 0", mult); end
        A = 8'd134;
        run(256);
        n_chk++;
        if (mult !== 8'd67) begin n_fail++; $display("FAIL load_clear_window: got %0d want 67", mult); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_pause();
        test_clear();
        test_async_reset();
        test_loadb_idle();
        test_load_and_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rep_umul.md
REP_UMUL -- requirements
Module: rep_umul

Interface
REQ-001 SHALL have parameter BITWIDTH, default 8, giving the operand/result width and the window length of 2^BITWIDTH enabled cycles; legal range 2..16.
REQ-002 SHALL have iClk  input  1  the only clock; all state changes on its rising edge.
REQ-003 SHALL have iRst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have A  input  BITWIDTH  unsigned multiplicand, sampled every enabled cycle, not registered.
REQ-005 SHALL have B  input  BITWIDTH  unsigned multiplier, captured into an internal register only on loadB.
REQ-006 SHALL have loadB  input  1  synchronous load strobe for the B register.
REQ-007 SHALL have iEn  input  1  synchronous enable: advances the bitstream and accumulation by one cycle.
REQ-008 SHALL have iClr  input  1  synchronous clear of the window counter, accumulator and result.
REQ-009 SHALL have mult  output  BITWIDTH  registered result of the last completed window, approximately A*Breg/2^BITWIDTH.

Function
REQ-010 SHALL hold internal state:
- Breg (BITWIDTH).
- Window counter cnt (BITWIDTH, wraps).
- Ones accumulator acc (BITWIDTH).
- Result register driving mult.
REQ-011 SHALL load Breg <= B on any clock edge with loadB=1, independent of iEn and iClr; the new value is used from the next cycle.
REQ-012 SHALL form the A stream bit as (A > cnt), unsigned compare.
REQ-013 SHALL form the B stream bit as (Breg > rev(cnt)), where rev is the bit-reversal of cnt (bit i maps to bit BITWIDTH-1-i).
REQ-014 SHALL form the product bit as the AND of the A and B stream bits, combinationally from the current cnt.
REQ-015 SHALL, on an edge with iEn=1 and iClr=0:
- Increment cnt modulo 2^BITWIDTH.
- If cnt != 2^BITWIDTH-1: acc <= acc + product bit.
- If cnt == 2^BITWIDTH-1 (last window cycle): mult <= acc + product bit and acc <= 0.
REQ-016 SHALL hold cnt, acc and mult unchanged on any edge with iEn=0 and iClr=0; a window may be paused and resumed without error.
REQ-017 SHALL update mult only at window completion, exactly once per 2^BITWIDTH enabled cycles; one-cycle latency from the last enabled edge; mult is stable between completions.
REQ-018 SHALL never overflow acc: the strict compare caps the ones count at 2^BITWIDTH-1 per window; no saturation logic.
REQ-019 SHALL, on an edge with iClr=1, set cnt, acc and mult to 0 regardless of iEn; Breg is not affected.
REQ-020 SHALL perform both the Breg load and the clear when loadB and iClr are high on the same edge.
REQ-021 SHALL, when Breg changes mid-window, leave that window's result as the mixed count; no error flag is raised.
REQ-022 SHALL produce an exact result of A*Breg/2^BITWIDTH over one full window whenever Breg is a power of two and A is a multiple of 2^BITWIDTH/Breg; other values give the deterministic low-discrepancy count.

Reset
REQ-023 SHALL, while iRst=1, asynchronously force Breg, cnt, acc and mult to 0; mult reads 0 immediately.
REQ-024 SHALL resume operation on the first rising edge after iRst deasserts, starting a fresh window at cnt=0.
REQ-025 SHALL discard a partially accumulated window when reset asserts mid-window.

Verification
REQ-026 SHALL pass: reset, load B=128, A=134, iEn=1 for 256 cycles -> mult=67 after the 256th enabled edge; mult stays 67 while iEn=0 and after 500 further enabled cycles (window 2 also 67).
REQ-027 SHALL pass: A=255, B=255, 256 enabled cycles -> mult=255; A=0 or B=0 -> mult=0.
REQ-028 SHALL pass: A=128, B=64, run 100 enabled cycles, drop iEn for 50 cycles, run 156 more -> mult=32; no change during the pause.
REQ-029 SHALL pass: iClr pulsed at cycle 100 of a window with iEn=1 -> mult=0 next edge; the following 256 enabled cycles give the full product; Breg is unchanged.
REQ-030 SHALL pass: iRst asserted mid-window, asynchronously between clock edges -> mult=0 at once; Breg=0, so a full window gives mult=0 until B is reloaded.
REQ-031 SHALL pass: loadB asserted with iEn=0 -> Breg updated, while cnt, acc and mult are unchanged.
